// File: rtl/stats_report_sequencer_if.sv
// stats_report_sequencer_if: valid/ready byte stream toward the UART transmitter
// tx_data  : byte offered to the transmitter
// tx_valid : tx_data is valid
// tx_ready : transmitter takes the byte this cycle
interface stats_report_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/stats_report_sequencer.sv
// stats_report_sequencer: sends one framed report (header, counters MSB-first, XOR checksum) per start
// clk, rst_n      : clock, async active-low reset
// start           : request a frame, only honoured in IDLE
// stat_words      : NUM_WORDS 32-bit counters, word k at [32k+31:32k]
// tx              : byte stream to the UART transmitter (master side)
// busy            : high while a frame is in progress, including the DONE cycle
// done            : one-cycle pulse after the checksum byte is taken
// frames_sent     : completed-frame counter, wraps at 256
module stats_report_sequencer #(
  parameter int         NUM_WORDS   = 5,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_WORDS*32-1:0]   stat_words,
  stats_report_sequencer_if.master  tx,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                frames_sent
);
  localparam int W = $clog2(4*NUM_WORDS);
  localparam logic [W-1:0] LAST = W'(4*NUM_WORDS-1);
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECKSUM, DONE} state_t;
  state_t state;
  logic [NUM_WORDS*32-1:0] snap;
  logic [W-1:0] idx, sel;
  logic [W+2:0] off;
  logic [7:0] csum, csum_n, nbyte;
  logic acc;
  assign acc = tx.tx_valid && tx.tx_ready;
  // tx_data is registered, so look up the byte that follows the one being accepted
  assign sel = state == HEADER ? idx : idx + 1'b1;
  // inverting the low two index bits turns byte-in-word order into MSB first
  assign off = {sel, 3'b000} ^ (W+3)'(24);
  assign nbyte = snap[off +: 8];
  assign csum_n = csum ^ tx.tx_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      snap        <= '0;
      idx         <= '0;
      csum        <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap        <= stat_words;
          csum        <= HEADER_BYTE;
          idx         <= '0;
          tx.tx_data  <= HEADER_BYTE;
          tx.tx_valid <= 1'b1;
          busy        <= 1'b1;
          state       <= HEADER;
        end
        HEADER: if (acc) begin
          tx.tx_data <= nbyte;
          state      <= PAYLOAD;
        end
        PAYLOAD: if (acc) begin
          csum       <= csum_n;
          idx        <= idx + 1'b1;
          tx.tx_data <= idx == LAST ? csum_n : nbyte;
          state      <= idx == LAST ? CHECKSUM : PAYLOAD;
        end
        CHECKSUM: if (acc) begin
          tx.tx_valid <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          frames_sent <= frames_sent + 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stats_report_sequencer.sv
// tb_stats_report_sequencer: directed checks of framing, handshake, snapshot, start filtering and reset
module tb_stats_report_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [159:0] stat_words = '0;
  logic busy, done;
  logic [7:0] frames_sent;
  stats_report_sequencer_if bus();
  stats_report_sequencer #(.NUM_WORDS(5), .HEADER_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stat_words(stat_words),
    .tx(bus), .busy(busy), .done(done), .frames_sent(frames_sent));
  always #5 clk = ~clk;
  localparam logic [159:0] W_BASIC = {32'h5, 32'hB, 32'h4, 32'hC, 32'h10};
  logic [7:0] exp_basic [22] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h0C,
                                 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0B,
                                 8'h00, 8'h00, 8'h00, 8'h05, 8'hB3};
  int n_cmp = 0, n_fail = 0;
  logic [7:0] got [64];
  int nb, dcnt, dcyc, ecyc, viol;
  logic [7:0] fs_end;
  logic d_busy, d_valid;
  bit tmo;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    start = 1'b0;
    bus.tx_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drives one frame from its start cycle (cycle 0) and records what was accepted.
  task automatic run_frame(input bit bp, input int chg_at, input logic [63:0] smask, input bit sdone);
    logic [7:0] pd;
    logic pv, pend;
    nb = 0; dcnt = 0; dcyc = -1; ecyc = -1; viol = 0; tmo = 1'b1;
    pend = 1'b0; pd = '0; pv = 1'b0; d_busy = 1'b0; d_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 400; c++) begin
      bus.tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == chg_at) stat_words = '1;
      start = (c < 64 && smask[c[5:0]]) || (sdone && done);
      if (pend && (bus.tx_data !== pd || bus.tx_valid !== pv)) viol++;
      if (bus.tx_valid && bus.tx_ready && nb < 64) begin
        got[nb] = bus.tx_data;
        nb++;
      end
      if (done) begin
        dcnt++;
        dcyc = c;
        d_busy = busy;
        d_valid = bus.tx_valid;
      end
      if (dcnt > 0 && !busy) begin
        ecyc = c;
        fs_end = frames_sent;
        tmo = 1'b0;
        start = 1'b0;
        break;
      end
      pend = bus.tx_valid && !bus.tx_ready;
      pd = bus.tx_data;
      pv = bus.tx_valid;
      tick();
    end
    start = 1'b0;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    start = 1'b0;
    bus.tx_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (frames_sent !== 8'h00) begin n_fail++; $display("FAIL reset_frames got %h want 00", frames_sent); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    do_reset();
    stat_words = W_BASIC;
    run_frame(1'b0, -1, 64'h0, 1'b0);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", tmo); end
    n_cmp++; if (nb !== 22) begin n_fail++; $display("FAIL basic_count got %0d want 22", nb); end
    for (int i = 0; i < 22; i++) begin
      n_cmp++; if (got[i] !== exp_basic[i]) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, got[i], exp_basic[i]); end
    end
    n_cmp++; if (dcnt !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", dcnt); end
    n_cmp++; if (dcyc !== 23) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 23", dcyc); end
    n_cmp++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL basic_done_busy got %b want 1", d_busy); end
    n_cmp++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done_valid got %b want 0", d_valid); end
    n_cmp++; if (ecyc !== 24) begin n_fail++; $display("FAIL basic_idle_cycle got %0d want 24", ecyc); end
    n_cmp++; if (fs_end !== 8'd1) begin n_fail++; $display("FAIL basic_frames got %0d want 1", fs_end); end
  endtask

  task automatic test_backpressure;
    do_reset();
    stat_words = W_BASIC;
    run_frame(1'b1, -1, 64'h0, 1'b0);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b want 0", tmo); end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", viol); end
    n_cmp++; if (nb !== 22) begin n_fail++; $display("FAIL bp_count got %0d want 22", nb); end
    for (int i = 0; i < 22; i++) begin
      n_cmp++; if (got[i] !== exp_basic[i]) begin n_fail++; $display("FAIL bp_byte%0d got %h want %h", i, got[i], exp_basic[i]); end
    end
    n_cmp++; if (dcnt !== 1) begin n_fail++; $display("FAIL bp_done_count got %0d want 1", dcnt); end
    n_cmp++; if (fs_end !== 8'd1) begin n_fail++; $display("FAIL bp_frames got %0d want 1", fs_end); end
  endtask

  task automatic test_snapshot;
    do_reset();
    stat_words = W_BASIC;
    run_frame(1'b0, 5, 64'h0, 1'b0);
    n_cmp++; if (nb !== 22) begin n_fail++; $display("FAIL snap_count got %0d want 22", nb); end
    for (int i = 0; i < 22; i++) begin
      n_cmp++; if (got[i] !== exp_basic[i]) begin n_fail++; $display("FAIL snap_byte%0d got %h want %h", i, got[i], exp_basic[i]); end
    end
    n_cmp++; if (got[21] !== 8'hB3) begin n_fail++; $display("FAIL snap_checksum got %h want B3", got[21]); end
    stat_words = W_BASIC;
  endtask

  task automatic test_start_busy;
    do_reset();
    stat_words = W_BASIC;
    run_frame(1'b0, -1, 64'h408, 1'b1);
    n_cmp++; if (dcnt !== 1) begin n_fail++; $display("FAIL busy_done_count got %0d want 1", dcnt); end
    n_cmp++; if (nb !== 22) begin n_fail++; $display("FAIL busy_count got %0d want 22", nb); end
    n_cmp++; if (fs_end !== 8'd1) begin n_fail++; $display("FAIL busy_frames got %0d want 1", fs_end); end
    repeat (5) tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b want 0", busy); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL busy_no_frame got %b want 0", bus.tx_valid); end
    n_cmp++; if (frames_sent !== 8'd1) begin n_fail++; $display("FAIL busy_frames_after got %0d want 1", frames_sent); end
  endtask

  task automatic test_all_zero;
    int total;
    bit any_tmo;
    logic [7:0] fs255;
    do_reset();
    stat_words = '0;
    run_frame(1'b0, -1, 64'h0, 1'b0);
    n_cmp++; if (nb !== 22) begin n_fail++; $display("FAIL zero_count got %0d want 22", nb); end
    n_cmp++; if (got[0] !== 8'hA5) begin n_fail++; $display("FAIL zero_header got %h want A5", got[0]); end
    for (int i = 1; i < 21; i++) begin
      n_cmp++; if (got[i] !== 8'h00) begin n_fail++; $display("FAIL zero_byte%0d got %h want 00", i, got[i]); end
    end
    n_cmp++; if (got[21] !== 8'hA5) begin n_fail++; $display("FAIL zero_checksum got %h want A5", got[21]); end
    total = dcnt;
    any_tmo = tmo;
    fs255 = '0;
    for (int k = 2; k <= 256; k++) begin
      run_frame(1'b0, -1, 64'h0, 1'b0);
      total += dcnt;
      any_tmo |= tmo;
      if (k == 255) fs255 = fs_end;
    end
    n_cmp++; if (any_tmo !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout got %b want 0", any_tmo); end
    n_cmp++; if (total !== 256) begin n_fail++; $display("FAIL wrap_done_total got %0d want 256", total); end
    n_cmp++; if (fs255 !== 8'd255) begin n_fail++; $display("FAIL wrap_frames255 got %0d want 255", fs255); end
    n_cmp++; if (fs_end !== 8'd0) begin n_fail++; $display("FAIL wrap_frames256 got %0d want 0", fs_end); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    stat_words = W_BASIC;
    run_frame(1'b0, -1, 64'h0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_tx_valid got %b want 0", bus.tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (frames_sent !== 8'd0) begin n_fail++; $display("FAIL mid_frames got %0d want 0", frames_sent); end
    repeat (3) tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b want 0", done); end
    rst_n = 1'b1;
    bus.tx_ready = 1'b0;
    tick();
    run_frame(1'b0, -1, 64'h0, 1'b0);
    n_cmp++; if (nb !== 22) begin n_fail++; $display("FAIL mid_count got %0d want 22", nb); end
    for (int i = 0; i < 22; i++) begin
      n_cmp++; if (got[i] !== exp_basic[i]) begin n_fail++; $display("FAIL mid_byte%0d got %h want %h", i, got[i], exp_basic[i]); end
    end
    n_cmp++; if (fs_end !== 8'd1) begin n_fail++; $display("FAIL mid_frames_after got %0d want 1", fs_end); end
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_start_busy();
    test_all_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
